dfp_mem_arbiter: RTL and testbench

//  Shares the single 256-bit line memory port between the I-cache (read-only
//  DFP) and the D-cache (read/write DFP). At most one transaction is outstanding.

---
 rtl/dfp_mem_arbiter.sv | 117 +++++++++++
 tb/tb_dfp_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dfp_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache and
// D-cache DFPs, with a single outstanding transaction and routed responses.
module dfp_mem_arbiter #(
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_dfp_addr,
  input  logic              i_dfp_read,
  output logic [LINE_W-1:0] i_dfp_rdata,
  output logic [31:0]       i_dfp_raddr,
  output logic              i_dfp_resp,
  input  logic [31:0]       d_dfp_addr,
  input  logic              d_dfp_read,
  input  logic              d_dfp_write,
  input  logic [LINE_W-1:0] d_dfp_wdata,
  output logic [LINE_W-1:0] d_dfp_rdata,
  output logic              d_dfp_resp,
  output logic [31:0]       mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic [31:0]       mem_raddr,
  input  logic              mem_resp,
  output logic              timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_RD, D_WR} state_t;

  state_t            state, state_nxt;
  logic              last_d, last_d_nxt;
  logic              grant;
  logic              i_req, d_req;
  logic              busy;
  logic [31:0]       addr_p1;
  logic [LINE_W-1:0] wdata_p1;
  logic [TW-1:0]     timer;

  assign i_req = i_dfp_read;
  assign d_req = d_dfp_read | d_dfp_write;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  // last_d resets high so the I-cache wins the first tie.
  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || last_d)) begin
          state_nxt  = I_BUSY;
          last_d_nxt = 1'b0;
          grant      = 1'b1;
        end else if (d_req) begin
          state_nxt  = d_dfp_write ? D_WR : D_RD;
          last_d_nxt = 1'b1;
          grant      = 1'b1;
        end
      end
      I_BUSY, D_RD, D_WR: begin
        if (mem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant stage: latch the winning transaction so requesters may drop inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else if (grant) begin
      addr_p1 <= (state_nxt == I_BUSY) ? {i_dfp_addr[31:5], 5'b0}
                                       : {d_dfp_addr[31:5], 5'b0};
      if (state_nxt == D_WR) wdata_p1 <= d_dfp_wdata;
    end
  end

  // Timer saturates so the sticky flag cannot be missed by wraparound.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant) timer <= '0;
      else if (busy && !mem_resp && timer != TMAX) timer <= timer + 1'b1;
      if (busy && timer == TMAX) timeout_err <= 1'b1;
    end
  end

  assign mem_read  = (state == I_BUSY) || (state == D_RD);
  assign mem_write = (state == D_WR);
  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;

  assign i_dfp_resp  = (state == I_BUSY) && mem_resp;
  assign d_dfp_resp  = ((state == D_RD) || (state == D_WR)) && mem_resp;
  assign i_dfp_rdata = mem_rdata;
  assign i_dfp_raddr = mem_raddr;
  assign d_dfp_rdata = mem_rdata;

endmodule

// File: tb/tb_dfp_mem_arbiter.sv
// Directed bench for dfp_mem_arbiter: grant order, latency, write hold,
// timeout flag and async reset behaviour.
module tb_dfp_mem_arbiter;
  localparam int LINE_W  = 256;
  localparam int TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       i_dfp_addr;
  logic              i_dfp_read;
  logic [LINE_W-1:0] i_dfp_rdata;
  logic [31:0]       i_dfp_raddr;
  logic              i_dfp_resp;
  logic [31:0]       d_dfp_addr;
  logic              d_dfp_read;
  logic              d_dfp_write;
  logic [LINE_W-1:0] d_dfp_wdata;
  logic [LINE_W-1:0] d_dfp_rdata;
  logic              d_dfp_resp;
  logic [31:0]       mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic [31:0]       mem_raddr;
  logic              mem_resp;
  logic              timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  dfp_mem_arbiter #(.LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read), .i_dfp_rdata(i_dfp_rdata),
    .i_dfp_raddr(i_dfp_raddr), .i_dfp_resp(i_dfp_resp),
    .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
    .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_raddr(mem_raddr),
    .mem_resp(mem_resp), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] line_x;

  initial begin
    rst = 1'b1;
    i_dfp_addr = '0; i_dfp_read = 1'b0;
    d_dfp_addr = '0; d_dfp_read = 1'b0; d_dfp_write = 1'b0; d_dfp_wdata = '0;
    mem_rdata = '0; mem_raddr = '0; mem_resp = 1'b0;
    pat_a5 = {32{8'hA5}};
    line_x = {8{32'hDEAD_BEEF}};
    step();
    step();

    // Reset state
    chk("rst_mem_read",  mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr",  mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_resp",    i_dfp_resp, 0);
    chk("rst_d_resp",    d_dfp_resp, 0);
    chk("rst_tmo",       timeout_err, 0);

    // 1: I-only read, response three cycles after mem_read
    rst = 1'b0;
    i_dfp_addr = 32'h0000_1234; i_dfp_read = 1'b1;
    step();
    chk("t1_mem_read",  mem_read, 1);
    chk("t1_mem_write", mem_write, 0);
    chk("t1_mem_addr",  mem_addr, 32'h0000_1220);
    step();
    chk("t1_i_resp_wait1", i_dfp_resp, 0);
    step();
    chk("t1_i_resp_wait2", i_dfp_resp, 0);
    step();
    mem_resp = 1'b1; mem_rdata = line_x; mem_raddr = 32'h0000_1220;
    #1;
    chk("t1_i_resp",  i_dfp_resp, 1);
    chk("t1_d_resp",  d_dfp_resp, 0);
    chk("t1_i_rdata", i_dfp_rdata, line_x);
    chk("t1_i_raddr", i_dfp_raddr, 32'h0000_1220);
    i_dfp_read = 1'b0;
    step();
    mem_resp = 1'b0;
    #1;
    chk("t1_i_resp_done", i_dfp_resp, 0);
    chk("t1_idle_read",   mem_read, 0);

    // 2 + 4: contention straight after reset, alternating I,D,I,D with M+2 reissue
    rst = 1'b1;
    i_dfp_read = 1'b1; i_dfp_addr = 32'h0000_2008;
    d_dfp_read = 1'b1; d_dfp_addr = 32'h0000_3010;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t2_mem_read", mem_read, 1);
      chk("t2_mem_addr", mem_addr, (k % 2 == 0) ? 32'h0000_2000 : 32'h0000_3000);
      mem_resp = 1'b1;
      #1;
      chk("t2_i_resp", i_dfp_resp, (k % 2 == 0) ? 1 : 0);
      chk("t2_d_resp", d_dfp_resp, (k % 2 == 0) ? 0 : 1);
      step();
      mem_resp = 1'b0;
      chk("t4_gap_m1", mem_read, 0);
      step();
    end
    i_dfp_read = 1'b0; d_dfp_read = 1'b0;
    mem_resp = 1'b1;
    #1;
    step();
    mem_resp = 1'b0;
    step();
    chk("t2_quiet", mem_read, 0);

    // 3: D writeback; inputs released after grant must not disturb the transaction
    d_dfp_addr = 32'h8000_0040; d_dfp_write = 1'b1; d_dfp_read = 1'b1; d_dfp_wdata = pat_a5;
    step();
    chk("t3_mem_write", mem_write, 1);
    chk("t3_mem_read",  mem_read, 0);
    chk("t3_mem_addr",  mem_addr, 32'h8000_0040);
    d_dfp_wdata = '0; d_dfp_write = 1'b0; d_dfp_read = 1'b0; d_dfp_addr = '0;
    step();
    chk("t3_wdata_hold1", mem_wdata, pat_a5);
    step();
    chk("t3_wdata_hold2", mem_wdata, pat_a5);
    chk("t3_write_hold",  mem_write, 1);
    mem_resp = 1'b1;
    #1;
    chk("t3_d_resp", d_dfp_resp, 1);
    chk("t3_i_resp", i_dfp_resp, 0);
    step();
    mem_resp = 1'b0;
    chk("t3_write_done", mem_write, 0);

    // 5: timeout flag sets and stays set after a late response
    i_dfp_addr = 32'h0000_4000; i_dfp_read = 1'b1;
    step();
    i_dfp_read = 1'b0;
    chk("t5_granted", mem_read, 1);
    for (int c = 0; c < 5; c++) step();
    chk("t5_tmo_early", timeout_err, 0);
    for (int c = 5; c < TIMEOUT + 2; c++) step();
    chk("t5_tmo_set",  timeout_err, 1);
    chk("t5_waiting",  mem_read, 1);
    mem_resp = 1'b1;
    #1;
    chk("t5_late_i_resp", i_dfp_resp, 1);
    step();
    mem_resp = 1'b0;
    step();
    chk("t5_tmo_sticky", timeout_err, 1);
    chk("t5_idle",       mem_read, 0);

    // 6: async reset in D_RD, stale mem_resp in IDLE is ignored
    do_reset();
    chk("t6_tmo_clr", timeout_err, 0);
    d_dfp_addr = 32'h0000_5000; d_dfp_read = 1'b1;
    step();
    chk("t6_d_rd", mem_read, 1);
    d_dfp_read = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_drop", mem_read, 0);
    step();
    rst = 1'b0;
    step();
    mem_resp = 1'b1;
    #1;
    chk("t6_stale_d_resp", d_dfp_resp, 0);
    chk("t6_stale_i_resp", i_dfp_resp, 0);
    chk("t6_stale_read",   mem_read, 0);
    step();
    mem_resp = 1'b0;
    chk("t6_still_idle", mem_read, 0);

    // Simultaneous read and write from D: write wins
    d_dfp_addr = 32'h0000_6000; d_dfp_read = 1'b1; d_dfp_write = 1'b1; d_dfp_wdata = line_x;
    step();
    d_dfp_read = 1'b0; d_dfp_write = 1'b0;
    chk("rw_write", mem_write, 1);
    chk("rw_read",  mem_read, 0);
    chk("rw_wdata", mem_wdata, line_x);
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
